// File: rtl/lcd_driver.sv
// HD44780-style write-cycle timing engine fed by the CPU's memory-mapped LCD register.
// Each toggle of lcd_reg_i[10] issues one timed write; one request can queue behind it.
module lcd_driver #(
   parameter int unsigned SETUP_CYC     = 2,
   parameter int unsigned EN_CYC        = 12,
   parameter int unsigned HOLD_CYC      = 2,
   parameter int unsigned EXEC_CYC      = 2000,
   parameter int unsigned LONG_EXEC_CYC = 82000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] lcd_reg_i,
   output logic [7:0]  lcd_data_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic        lcd_on_o,
   output logic        lcd_busy_o,
   output logic        lcd_ovf_o
);

   localparam int unsigned CntW = $clog2(LONG_EXEC_CYC + 1);

   localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
   localparam logic [CntW-1:0] EnLd    = CntW'(EN_CYC - 1);
   localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);
   localparam logic [CntW-1:0] ExecLd  = CntW'(EXEC_CYC - 1);
   localparam logic [CntW-1:0] LongLd  = CntW'(LONG_EXEC_CYC - 1);

   typedef enum logic [2:0] {StIdle, StSetup, StEnh, StHold, StExec} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic            prev_tgl_q;
   logic            primed_q;
   logic            pend_v_q;
   logic            pend_rs_q;
   logic [7:0]      pend_data_q;
   logic            rs_q;
   logic [7:0]      data_q;
   logic            en_q;
   logic            on_q;
   logic            ovf_q;

   logic            evt;
   logic            evt_rs;
   logic [7:0]      evt_data;
   logic            last_cyc;
   logic            exec_end;
   logic            cur_long;
   logic            unused_bits;

   // primed_q suppresses a spurious event on the first clock after reset release
   assign evt      = primed_q & (lcd_reg_i[10] != prev_tgl_q);
   assign evt_rs   = lcd_reg_i[9];
   assign evt_data = lcd_reg_i[7:0];
   assign last_cyc = (cnt_q == '0);
   assign exec_end = (state_q == StExec) & last_cyc;

   // Clear (0x01) and return-home (0x02/0x03) need the long execution wait
   assign cur_long = ~rs_q & (data_q[7:2] == 6'd0) & (data_q != 8'd0);

   assign unused_bits = ^{lcd_reg_i[30:11], lcd_reg_i[8]};

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         prev_tgl_q  <= 1'b0;
         primed_q    <= 1'b0;
         pend_v_q    <= 1'b0;
         pend_rs_q   <= 1'b0;
         pend_data_q <= 8'h00;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
         en_q        <= 1'b0;
         on_q        <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         prev_tgl_q <= lcd_reg_i[10];
         primed_q   <= 1'b1;
         on_q       <= lcd_reg_i[31];

         unique case (state_q)
            StIdle: begin
               if (evt) begin
                  rs_q    <= evt_rs;
                  data_q  <= evt_data;
                  cnt_q   <= SetupLd;
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               if (last_cyc) begin
                  en_q    <= 1'b1;
                  cnt_q   <= EnLd;
                  state_q <= StEnh;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            StEnh: begin
               if (last_cyc) begin
                  en_q    <= 1'b0;
                  cnt_q   <= HoldLd;
                  state_q <= StHold;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            StHold: begin
               if (last_cyc) begin
                  cnt_q   <= cur_long ? LongLd : ExecLd;
                  state_q <= StExec;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            StExec: begin
               if (last_cyc) begin
                  cnt_q   <= SetupLd;
                  state_q <= StSetup;
                  if (pend_v_q) begin
                     // Pending entry issues now; a same-cycle event takes its slot
                     rs_q        <= pend_rs_q;
                     data_q      <= pend_data_q;
                     pend_v_q    <= evt;
                     pend_rs_q   <= evt_rs;
                     pend_data_q <= evt_data;
                  end else if (evt) begin
                     rs_q   <= evt_rs;
                     data_q <= evt_data;
                  end else begin
                     cnt_q   <= '0;
                     state_q <= StIdle;
                  end
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            default: begin
               en_q    <= 1'b0;
               cnt_q   <= '0;
               state_q <= StIdle;
            end
         endcase

         if (evt && (state_q != StIdle) && !exec_end) begin
            if (pend_v_q) begin
               ovf_q <= 1'b1;
            end else begin
               pend_v_q    <= 1'b1;
               pend_rs_q   <= evt_rs;
               pend_data_q <= evt_data;
            end
         end
      end
   end

   assign lcd_data_o = data_q;
   assign lcd_rs_o   = rs_q;
   assign lcd_rw_o   = 1'b0;
   assign lcd_en_o   = en_q;
   assign lcd_on_o   = on_q;
   assign lcd_busy_o = (state_q != StIdle) | pend_v_q;
   assign lcd_ovf_o  = ovf_q;

endmodule

// File: tb/tb_lcd_driver.sv
// Randomized bench for lcd_driver against a timestamp-based model of LCD write transactions.
// Each transaction is a start cycle plus a duration; EN and busy windows derive from it.
module tb_lcd_driver;

   localparam int unsigned SETUP = 2;
   localparam int unsigned EN    = 4;
   localparam int unsigned HOLD  = 2;
   localparam int unsigned EXEC  = 10;
   localparam int unsigned LONG  = 30;

   logic        clk_i;
   logic        rst_ni;
   logic [31:0] lcd_reg_i;
   logic [7:0]  lcd_data_o;
   logic        lcd_rs_o;
   logic        lcd_rw_o;
   logic        lcd_en_o;
   logic        lcd_on_o;
   logic        lcd_busy_o;
   logic        lcd_ovf_o;

   lcd_driver #(
      .SETUP_CYC     (SETUP),
      .EN_CYC        (EN),
      .HOLD_CYC      (HOLD),
      .EXEC_CYC      (EXEC),
      .LONG_EXEC_CYC (LONG)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .lcd_reg_i  (lcd_reg_i),
      .lcd_data_o (lcd_data_o),
      .lcd_rs_o   (lcd_rs_o),
      .lcd_rw_o   (lcd_rw_o),
      .lcd_en_o   (lcd_en_o),
      .lcd_on_o   (lcd_on_o),
      .lcd_busy_o (lcd_busy_o),
      .lcd_ovf_o  (lcd_ovf_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit tgl      = 1'b0;
   bit cur_on   = 1'b0;

   // Reference model: current transaction window, one pending slot, sticky overflow
   bit         m_act   = 1'b0;
   int         m_start = 0;
   int         m_end   = -1;
   bit         m_rs    = 1'b0;
   logic [7:0] m_data  = 8'h00;
   bit         m_pv    = 1'b0;
   bit         m_prs   = 1'b0;
   logic [7:0] m_pd    = 8'h00;
   bit         m_ovf   = 1'b0;
   bit         m_on    = 1'b0;

   function automatic int dur(input bit rs, input logic [7:0] d);
      return SETUP + EN + HOLD + ((!rs && d >= 8'd1 && d <= 8'd3) ? LONG : EXEC);
   endfunction

   task automatic model_start(input bit rs, input logic [7:0] d, input int s);
      m_act   = 1'b1;
      m_start = s;
      m_end   = s + dur(rs, d) - 1;
      m_rs    = rs;
      m_data  = d;
   endtask

   task automatic model_cycle(input bit ev, input bit rs, input logic [7:0] d);
      int c;
      c = cyc;
      if (m_act && c == m_end) begin
         if (m_pv) begin
            model_start(m_prs, m_pd, c + 1);
            if (ev) begin
               m_prs = rs;
               m_pd  = d;
            end else begin
               m_pv = 1'b0;
            end
         end else if (ev) begin
            model_start(rs, d, c + 1);
         end else begin
            m_act = 1'b0;
         end
      end else if (m_act) begin
         if (ev) begin
            if (m_pv) m_ovf = 1'b1;
            else begin
               m_pv  = 1'b1;
               m_prs = rs;
               m_pd  = d;
            end
         end
      end else if (ev) begin
         model_start(rs, d, c + 1);
      end
      m_on = cur_on;
   endtask

   task automatic model_reset();
      m_act  = 1'b0;
      m_pv   = 1'b0;
      m_ovf  = 1'b0;
      m_on   = 1'b0;
      m_rs   = 1'b0;
      m_data = 8'h00;
   endtask

   function automatic logic [13:0] obs_vec();
      return {lcd_en_o, lcd_busy_o, lcd_rs_o, lcd_data_o, lcd_ovf_o, lcd_on_o, lcd_rw_o};
   endfunction

   function automatic logic [13:0] exp_vec();
      logic en;
      en = m_act && (cyc >= m_start + int'(SETUP)) && (cyc < m_start + int'(SETUP + EN));
      return {en, m_act | m_pv, m_rs, m_data, m_ovf, m_on, 1'b0};
   endfunction

   // Presents one cycle of register input; outputs are sampled 1 time unit after the edge
   task automatic step(input bit ev, input bit rs, input logic [7:0] d);
      if (ev) tgl = ~tgl;
      lcd_reg_i = {cur_on, 20'($urandom), tgl, rs, 1'($urandom), d};
      model_cycle(ev, rs, d);
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic apply_reset(input logic [31:0] val);
      rst_ni    = 1'b0;
      lcd_reg_i = val;
      tgl       = val[10];
      cur_on    = val[31];
      repeat (2) begin
         @(posedge clk_i);
         #1;
         cyc++;
      end
      model_reset();
   endtask

   task automatic test_reset();
      int en_seen;
      en_seen = 0;
      apply_reset(32'h0000_0400);
      n_checks++;
      if (obs_vec() !== 14'h0000) $display("FAIL reset_vals got=%h exp=%h", obs_vec(), 14'h0);
      else n_pass++;
      rst_ni = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b0, 8'h00);
         if (lcd_en_o) en_seen++;
         n_checks++;
         if (obs_vec() !== exp_vec())
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (en_seen !== 0) $display("FAIL reset_no_en got=%0d exp=0", en_seen);
      else n_pass++;
   endtask

   task automatic test_short_write();
      int busy_n, en_n;
      busy_n = 0;
      en_n   = 0;
      for (int i = 0; i < 25; i++) begin
         step(i == 0, 1'b1, 8'h41);
         if (i == 0) begin
            n_checks++;
            if ({lcd_busy_o, lcd_rs_o, lcd_data_o, lcd_en_o} !== {1'b1, 1'b1, 8'h41, 1'b0})
               $display("FAIL short_first got=%b%b%h%b exp=11410", lcd_busy_o, lcd_rs_o,
                        lcd_data_o, lcd_en_o);
            else n_pass++;
         end
         if (lcd_busy_o) busy_n++;
         if (lcd_en_o) en_n++;
         n_checks++;
         if (obs_vec() !== exp_vec())
            $display("FAIL short cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (busy_n !== 18) $display("FAIL short_busy_len got=%0d exp=18", busy_n);
      else n_pass++;
      n_checks++;
      if (en_n !== 4) $display("FAIL short_en_len got=%0d exp=4", en_n);
      else n_pass++;
   endtask

   task automatic test_long();
      bit         rs_t [3] = '{1'b0, 1'b0, 1'b1};
      logic [7:0] d_t  [3] = '{8'h01, 8'h80, 8'h02};
      int         exp_t[3] = '{38, 18, 18};
      int busy_n;
      for (int t = 0; t < 3; t++) begin
         busy_n = 0;
         for (int i = 0; i < 45; i++) begin
            step(i == 0, rs_t[t], d_t[t]);
            if (lcd_busy_o) busy_n++;
            n_checks++;
            if (obs_vec() !== exp_vec())
               $display("FAIL long cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            else n_pass++;
         end
         n_checks++;
         if (busy_n !== exp_t[t])
            $display("FAIL long_busy_len d=%h got=%0d exp=%0d", d_t[t], busy_n, exp_t[t]);
         else n_pass++;
      end
   endtask

   task automatic test_display_power();
      cur_on = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      n_checks++;
      if ({lcd_on_o, lcd_en_o, lcd_busy_o} !== 3'b100)
         $display("FAIL power_on got=%b%b%b exp=100", lcd_on_o, lcd_en_o, lcd_busy_o);
      else n_pass++;
      cur_on = 1'b0;
      step(1'b0, 1'b0, 8'h00);
      n_checks++;
      if (obs_vec() !== exp_vec())
         $display("FAIL power_off got=%h exp=%h", obs_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_queueing();
      int pulses, busy_n;
      bit prev_en;
      pulses  = 0;
      busy_n  = 0;
      prev_en = 1'b0;
      for (int i = 0; i < 70; i++) begin
         step(i == 0 || i == 4 || i == 6, 1'b1, 8'h50 + 8'(i));
         if (lcd_en_o && !prev_en) pulses++;
         prev_en = lcd_en_o;
         if (lcd_busy_o) busy_n++;
         n_checks++;
         if (obs_vec() !== exp_vec())
            $display("FAIL queue cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (pulses !== 2) $display("FAIL queue_pulses got=%0d exp=2", pulses);
      else n_pass++;
      n_checks++;
      if (busy_n !== 36) $display("FAIL queue_busy_len got=%0d exp=36", busy_n);
      else n_pass++;
      n_checks++;
      if (lcd_ovf_o !== 1'b1) $display("FAIL queue_ovf got=%b exp=1", lcd_ovf_o);
      else n_pass++;
   endtask

   task automatic test_boundary();
      int pulses;
      bit prev_en;
      apply_reset(32'h0);
      rst_ni = 1'b1;
      step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h33);
      for (int k = 0; k < 60 && cyc != m_end; k++) begin
         step(1'b0, 1'b0, 8'h00);
         n_checks++;
         if (obs_vec() !== exp_vec())
            $display("FAIL bnd_a cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         else n_pass++;
      end
      step(1'b1, 1'b1, 8'h44);
      n_checks++;
      if ({lcd_busy_o, lcd_en_o, lcd_data_o} !== {1'b1, 1'b0, 8'h44})
         $display("FAIL bnd_empty got=%b%b%h exp=1044", lcd_busy_o, lcd_en_o, lcd_data_o);
      else n_pass++;
      repeat (3) step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h55);
      for (int k = 0; k < 60 && cyc != m_end; k++) begin
         step(1'b0, 1'b0, 8'h00);
         n_checks++;
         if (obs_vec() !== exp_vec())
            $display("FAIL bnd_b cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         else n_pass++;
      end
      step(1'b1, 1'b1, 8'h66);
      pulses  = 0;
      prev_en = lcd_en_o;
      for (int i = 0; i < 50; i++) begin
         step(1'b0, 1'b0, 8'h00);
         if (lcd_en_o && !prev_en) pulses++;
         prev_en = lcd_en_o;
         n_checks++;
         if (obs_vec() !== exp_vec())
            $display("FAIL bnd_c cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (pulses !== 2) $display("FAIL bnd_refill_pulses got=%0d exp=2", pulses);
      else n_pass++;
      n_checks++;
      if (lcd_ovf_o !== 1'b0) $display("FAIL bnd_refill_ovf got=%b exp=0", lcd_ovf_o);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int en_n;
      en_n = 0;
      step(1'b1, 1'b1, 8'h21);
      repeat (3) step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h22);
      n_checks++;
      if ({lcd_en_o, lcd_busy_o} !== 2'b11)
         $display("FAIL rmid_pre got=%b%b exp=11", lcd_en_o, lcd_busy_o);
      else n_pass++;
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      cyc++;
      model_reset();
      n_checks++;
      if ({lcd_en_o, lcd_busy_o} !== 2'b00)
         $display("FAIL rmid_post got=%b%b exp=00", lcd_en_o, lcd_busy_o);
      else n_pass++;
      rst_ni = 1'b1;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b0, 8'h00);
         if (lcd_en_o) en_n++;
         n_checks++;
         if (obs_vec() !== exp_vec())
            $display("FAIL rmid cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (en_n !== 0) $display("FAIL rmid_no_en got=%0d exp=0", en_n);
      else n_pass++;
   endtask

   task automatic test_random();
      bit         ev, rs;
      logic [7:0] d;
      for (int i = 0; i < 800; i++) begin
         ev = ($urandom_range(0, 9) == 0);
         rs = 1'($urandom);
         d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         if ($urandom_range(0, 49) == 0) cur_on = ~cur_on;
         step(ev, rs, d);
         n_checks++;
         if (obs_vec() !== exp_vec())
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
         else n_pass++;
      end
   endtask

   initial begin
      rst_ni    = 1'b0;
      lcd_reg_i = 32'h0;
      test_reset();
      test_short_write();
      test_long();
      test_display_power();
      test_queueing();
      test_boundary();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
